apb_master_arbiter: RTL and testbench

- Shares one APB master port between NUM_REQ local requesters, e.g. the write and read agents' request paths, and presents one APB completer (the APB RAM) to them.
- Arbitrates round-robin and sequences the APB SETUP and ACCESS phases.
- Handles pready wait states and aborts a stalled transfer with a timeout.
- Returns per-requester response pulses carrying prdata and pslverr.

---
 rtl/apb_ctrl_pkg.sv | 13 +
 rtl/apb_master_arbiter_rr_arbiter.sv | 36 +++
 rtl/apb_master_arbiter.sv | 118 +++++++++++
 tb/tb_apb_master_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_ctrl_pkg.sv
// Shared types and sizing helpers for the APB master arbiter.
package apb_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the requester at ptr has highest priority.
module rr_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx
);

    int               sum;
    logic [PTR_W-1:0] cand;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = 0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(ptr) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            cand = PTR_W'(sum);
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NUM_REQ requesters with round-robin
// arbitration, wait-state handling and a stalled-transfer timeout.
//   state  | meaning
//   IDLE   | no transfer; accepts the arbiter's winner
//   SETUP  | psel high, penable low, address/data presented
//   ACCESS | psel and penable high, waiting for pready or timeout
module apb_master_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                      clk,
    input  logic                      preset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_slverr,
    output logic                      rsp_timeout,
    output logic                      busy,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [DATA_W-1:0]         prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    localparam int PTR_W = clog2_min1(NUM_REQ);
    localparam int WC_W  = clog2_min1(TIMEOUT_CYC + 1);
    localparam logic [WC_W-1:0] WC_LAST = (TIMEOUT_CYC == 0) ? '0 : WC_W'(TIMEOUT_CYC - 1);

    apb_state_t       state, next_state;
    logic [PTR_W-1:0] rr_ptr, grant_idx, lat_idx;
    logic [NUM_REQ-1:0] grant;
    logic             lat_write;
    logic [WC_W-1:0]  wait_cnt;
    logic             accept, timeout_hit, complete;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign accept      = (state == IDLE) && (|req_valid);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (wait_cnt == WC_LAST) && !pready;
    assign complete    = (state == ACCESS) && (pready || timeout_hit);

    always_ff @(posedge clk) begin
        if (preset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (pready || timeout_hit) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE) ? grant : '0;
    assign busy      = (state != IDLE);
    assign psel      = (state != IDLE);
    assign penable   = (state == ACCESS);
    assign pwrite    = (state != IDLE) && lat_write;

    always_ff @(posedge clk) begin
        if (preset) begin
            rr_ptr      <= '0;
            lat_idx     <= '0;
            lat_write   <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            wait_cnt    <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
            if (accept) begin
                lat_idx   <= grant_idx;
                lat_write <= req_write[grant_idx];
                paddr     <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                pwdata    <= req_wdata[grant_idx*DATA_W +: DATA_W];
                rr_ptr    <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            // Saturating so a disabled timeout can never alias back to zero.
            if (state == SETUP)
                wait_cnt <= '0;
            else if (state == ACCESS && wait_cnt != '1)
                wait_cnt <= wait_cnt + 1'b1;
            if (complete) begin
                rsp_valid[lat_idx] <= 1'b1;
                rsp_rdata          <= (pready && !lat_write) ? prdata : '0;
                rsp_slverr         <= pready ? pslverr : 1'b1;
                rsp_timeout        <= !pready;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomized and directed bench for apb_master_arbiter; the bench acts as the APB RAM.
module tb_apb_master_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            preset;
    logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, pwdata, prdata;
    logic [AW-1:0]   paddr;
    logic            rsp_slverr, rsp_timeout, busy, psel, penable, pwrite, pready, pslverr;

    apb_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .preset(preset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .rsp_timeout(rsp_timeout), .busy(busy), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_ptr = 0;
    logic [31:0] mem [logic [31:0]];
    logic        r_wr   [N];
    logic [31:0] r_addr [N];
    logic [31:0] r_wd   [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++)
            if (m[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic drive_reqs(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) begin
            req_valid[i]            = m[i];
            req_write[i]            = r_wr[i];
            req_addr[i*AW +: AW]    = r_addr[i];
            req_wdata[i*DW +: DW]   = r_wd[i];
        end
    endtask

    // One transfer from the winner of mask; waits >= TO means pready never comes.
    task automatic xfer(input logic [N-1:0] mask, input int waits, input bit err);
        int w, lat, acc_n, exp_lat;
        bit done, timed, wr;
        logic [31:0] a, d, exp_rd;
        w = rr_pick(mask, exp_ptr);
        drive_reqs(mask);
        #1;
        chk("req_ready_grant", req_ready, oh(w));
        @(posedge clk); #1;
        exp_ptr   = (w + 1) % N;
        req_valid = '0;
        wr = r_wr[w]; a = r_addr[w]; d = r_wd[w];
        timed   = (waits >= TO);
        exp_lat = timed ? 2 + TO : 3 + waits;
        lat = 1; acc_n = 0; done = 0;
        while (!done && lat < 40) begin
            if (rsp_valid != '0) begin
                done = 1;
            end else begin
                if (psel && !penable) begin
                    chk("setup_paddr", paddr, a);
                    chk("setup_pwrite", pwrite, wr);
                    if (wr) chk("setup_pwdata", pwdata, d);
                    pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
                end else if (psel && penable) begin
                    chk("access_paddr", paddr, a);
                    chk("access_pwrite", pwrite, wr);
                    if (acc_n == waits) begin
                        pready = 1'b1; pslverr = err; prdata = wr ? $urandom : mem_rd(a);
                    end else begin
                        pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
                    end
                    acc_n++;
                end else begin
                    chk("psel_during_xfer", psel, 1'b1);
                end
                @(posedge clk); #1;
                lat++;
            end
        end
        chk("rsp_seen", done, 1'b1);
        exp_rd = (timed || wr) ? 32'h0 : mem_rd(a);
        chk("rsp_latency", lat, exp_lat);
        chk("access_cycles", acc_n, timed ? TO : waits + 1);
        chk("rsp_valid", rsp_valid, oh(w));
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_slverr", rsp_slverr, timed ? 1'b1 : err);
        chk("rsp_timeout", rsp_timeout, timed);
        chk("idle_psel", {psel, penable, pwrite}, 3'b000);
        if (wr && !timed && !err) mem[a] = d;
        pready = 1'b0; pslverr = 1'b0;
        @(posedge clk); #1;
        chk("rsp_pulse_end", rsp_valid, '0);
        chk("rsp_rdata_idle", {rsp_rdata, rsp_slverr, rsp_timeout}, '0);
        chk("busy_idle", busy, 1'b0);
    endtask

    // All requesters hold valid; accepts must land every 3 cycles in rotation.
    task automatic contend(input int n);
        int w, prev;
        int cnt [N];
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0; r_wr[i] = 1'b1; r_addr[i] = 32'h100 + 32'(i * 4); r_wd[i] = $urandom;
        end
        drive_reqs('1);
        #1;
        prev = -1;
        for (int t = 0; t < n; t++) begin
            w = rr_pick('1, exp_ptr);
            chk("rr_grant", req_ready, oh(w));
            if (prev >= 0) chk("b2b_rsp", rsp_valid, oh(prev));
            @(posedge clk); #1;
            cnt[w]++;
            exp_ptr = (w + 1) % N;
            mem[r_addr[w]] = r_wd[w];
            r_wd[w] = $urandom;
            drive_reqs('1);
            pready = 1'b1; pslverr = 1'b0; prdata = $urandom;
            chk("b2b_setup_ready", {req_ready, psel, penable}, {{N{1'b0}}, 2'b10});
            @(posedge clk); #1;
            chk("b2b_access_ready", {req_ready, psel, penable}, {{N{1'b0}}, 2'b11});
            @(posedge clk); #1;
            prev = w;
        end
        req_valid = '0; pready = 1'b0;
        chk("b2b_last_rsp", rsp_valid, oh(prev));
        for (int i = 0; i < N; i++) chk("no_starve", cnt[i], n / N);
        @(posedge clk); #1;
    endtask

    initial begin
        preset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        for (int i = 0; i < N; i++) begin r_wr[i] = 0; r_addr[i] = 0; r_wd[i] = 0; end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_apb", {psel, penable, pwrite, busy}, 4'b0);
        chk("rst_paddr", paddr, '0);
        chk("rst_pwdata", pwdata, '0);
        chk("rst_rsp", {rsp_valid, rsp_slverr, rsp_timeout}, '0);
        chk("rst_rdata", rsp_rdata, '0);
        chk("rst_ready", req_ready, '0);
        preset = 1'b0;
        @(posedge clk); #1;

        r_wr[0] = 1; r_addr[0] = 32'h10; r_wd[0] = 32'hDEADBEEF;
        xfer(2'b01, 0, 0);
        r_wr[0] = 0;
        xfer(2'b01, 0, 0);
        chk("readback_0x10", mem_rd(32'h10), 32'hDEADBEEF);

        contend(8);

        r_wr[1] = 0; r_addr[1] = 32'h10;
        xfer(2'b10, 3, 0);

        r_wr[0] = 0; r_addr[0] = 32'h104;
        xfer(2'b01, 30, 0);
        r_wr[1] = 1; r_addr[1] = 32'h20; r_wd[1] = 32'h12345678;
        xfer(2'b10, 0, 0);

        r_wr[0] = 0; r_addr[0] = 32'h40;
        xfer(2'b01, 0, 1);

        // Reset in ACCESS with rr_ptr advanced to 1.
        r_wr[0] = 0; r_addr[0] = 32'h80;
        drive_reqs(2'b01);
        @(posedge clk); #1;
        req_valid = '0; pready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_access", {psel, penable}, 2'b11);
        preset = 1'b1;
        @(posedge clk); #1;
        chk("rst_abort_apb", {psel, penable, busy}, 3'b000);
        chk("rst_abort_rsp", rsp_valid, '0);
        chk("rst_abort_paddr", paddr, '0);
        preset = 1'b0;
        exp_ptr = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_no_rsp", rsp_valid, '0);
        end
        r_wr[0] = 1; r_addr[0] = 32'h30; r_wd[0] = 32'hA5A5A5A5;
        r_wr[1] = 1; r_addr[1] = 32'h34; r_wd[1] = 32'h5A5A5A5A;
        xfer(2'b11, 0, 0);

        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] m;
            int wt;
            m = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                r_wr[i] = 1'($urandom); r_addr[i] = 32'($urandom_range(0, 15)) << 2; r_wd[i] = $urandom;
            end
            wt = ($urandom_range(0, 9) == 0) ? 17 : $urandom_range(0, 3);
            xfer(m, wt, $urandom_range(0, 7) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=stuck expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
